// File: rtl/fpu_wb_arbiter_if.sv
// rtl/fpu_wb_arbiter_if.sv - issue, unit-result and merged-result bus of the FPU writeback arbiter
//
// Groups every handshake/bus signal of fpu_wb_arbiter. Clock and reset stay
// plain ports on the arbiter itself.
//   issue_*       : issue request (unit index + destination tag) and issue_ready_o
//   unit_*        : per-unit one-cycle result strobes, packed results and fflags
//   result_*      : merged valid/ready result stream (result, flags, tag, unit)
//   busy_o, err_o : activity and sticky protocol-error status
// Modport slave is the arbiter side; modport master is the issue/consumer side.
interface fpu_wb_arbiter_if #(
  parameter int NUM_UNITS  = 3,
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 5,
  parameter int TAG_WIDTH  = 5,
  parameter int UW         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
);
  logic                             issue_valid_i;
  logic [UW-1:0]                    issue_unit_i;
  logic [TAG_WIDTH-1:0]             issue_tag_i;
  logic                             issue_ready_o;
  logic [NUM_UNITS-1:0]             unit_valid_i;
  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_result_i;
  logic [NUM_UNITS*FLAG_WIDTH-1:0]  unit_flags_i;
  logic                             result_valid_o;
  logic                             result_ready_i;
  logic [DATA_WIDTH-1:0]            result_o;
  logic [FLAG_WIDTH-1:0]            flags_o;
  logic [TAG_WIDTH-1:0]             tag_o;
  logic [UW-1:0]                    unit_o;
  logic                             busy_o;
  logic                             err_o;

  modport slave (
    input  issue_valid_i, issue_unit_i, issue_tag_i,
    input  unit_valid_i, unit_result_i, unit_flags_i,
    input  result_ready_i,
    output issue_ready_o, result_valid_o, result_o, flags_o, tag_o, unit_o,
    output busy_o, err_o
  );

  modport master (
    output issue_valid_i, issue_unit_i, issue_tag_i,
    output unit_valid_i, unit_result_i, unit_flags_i,
    output result_ready_i,
    input  issue_ready_o, result_valid_o, result_o, flags_o, tag_o, unit_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/fpu_wb_arbiter.sv
// rtl/fpu_wb_arbiter.sv - credit-tracked, round-robin writeback arbiter for FPU functional units
//
// Each unit k owns a credit counter (ops issued, not yet written back), a tag
// FIFO pushed at issue and a {result, flags} FIFO pushed on its result strobe.
// Non-empty result FIFOs compete round-robin for the single merged output.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : fpu_wb_arbiter_if.slave (issue, unit results, merged result, status)
module fpu_wb_arbiter #(
  parameter int NUM_UNITS  = 3,
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 5,
  parameter int TAG_WIDTH  = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fpu_wb_arbiter_if.slave     bus
);
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = DATA_WIDTH + FLAG_WIDTH;

  // cnt counts tags held (issued, not yet popped); rcnt counts results held.
  // rcnt <= cnt always, so the result FIFO can never overflow.
  logic [CW-1:0] cnt_q    [NUM_UNITS];
  logic [CW-1:0] cnt_d    [NUM_UNITS];
  logic [CW-1:0] rcnt_q   [NUM_UNITS];
  logic [CW-1:0] rcnt_d   [NUM_UNITS];
  logic [PW-1:0] tag_wp_q [NUM_UNITS];
  logic [PW-1:0] tag_wp_d [NUM_UNITS];
  logic [PW-1:0] tag_rp_q [NUM_UNITS];
  logic [PW-1:0] tag_rp_d [NUM_UNITS];
  logic [PW-1:0] res_wp_q [NUM_UNITS];
  logic [PW-1:0] res_wp_d [NUM_UNITS];
  logic [PW-1:0] res_rp_q [NUM_UNITS];
  logic [PW-1:0] res_rp_d [NUM_UNITS];
  logic [UW-1:0] rr_q, rr_d;
  logic [UW-1:0] lock_unit_q, lock_unit_d;
  logic          lock_q, lock_d;
  logic          err_q, err_d;

  logic [TAG_WIDTH-1:0] tag_mem [NUM_UNITS][FIFO_DEPTH];
  logic [RW-1:0]        res_mem [NUM_UNITS][FIFO_DEPTH];

  logic [NUM_UNITS-1:0] nonempty, tag_push, res_push, pop;
  logic [UW-1:0]        pick, grant;
  logic                 found, any_valid, hs;
  logic                 issue_bad, issue_full, issue_fire, busy;
  logic [TAG_WIDTH-1:0] head_tag;
  logic [RW-1:0]        head_res;
  int                   idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick: first non-empty unit at or after rr_q, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      nonempty[k] = (rcnt_q[k] != '0);
    end
    for (int i = 0; i < NUM_UNITS; i++) begin
      idx = (int'(rr_q) + i) % NUM_UNITS;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        pick  = UW'(idx);
      end
    end
  end

  // A stalled grant is held so the presented result cannot change under the consumer.
  assign grant     = lock_q ? lock_unit_q : pick;
  assign any_valid = |nonempty;
  assign hs        = any_valid & bus.result_ready_i;

  always_comb begin
    issue_bad  = (int'(bus.issue_unit_i) >= NUM_UNITS);
    issue_full = 1'b0;
    busy       = 1'b0;
    head_tag   = '0;
    head_res   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (bus.issue_unit_i == UW'(k) && cnt_q[k] == CW'(FIFO_DEPTH)) begin
        issue_full = 1'b1;
      end
      if (cnt_q[k] != '0) begin
        busy = 1'b1;
      end
      if (grant == UW'(k)) begin
        head_tag = tag_mem[k][tag_rp_q[k]];
        head_res = res_mem[k][res_rp_q[k]];
      end
    end
    issue_fire = bus.issue_valid_i & ~issue_bad & ~issue_full;
  end

  always_comb begin
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    tag_wp_d    = tag_wp_q;
    tag_rp_d    = tag_rp_q;
    res_wp_d    = res_wp_q;
    res_rp_d    = res_rp_q;
    rr_d        = rr_q;
    lock_d      = any_valid & ~bus.result_ready_i;
    lock_unit_d = grant;
    err_d       = err_q;
    tag_push    = '0;
    res_push    = '0;
    pop         = '0;

    if (bus.issue_valid_i && issue_bad) begin
      err_d = 1'b1;
    end

    for (int k = 0; k < NUM_UNITS; k++) begin
      tag_push[k] = issue_fire && (bus.issue_unit_i == UW'(k));
      pop[k]      = hs && (grant == UW'(k));
      // Only ops still waiting for data may accept a strobe; anything else is dropped.
      res_push[k] = bus.unit_valid_i[k] && (cnt_q[k] > rcnt_q[k]);
      if (bus.unit_valid_i[k] && !(cnt_q[k] > rcnt_q[k])) begin
        err_d = 1'b1;
      end

      if (tag_push[k] && !pop[k]) begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end else if (!tag_push[k] && pop[k]) begin
        cnt_d[k] = cnt_q[k] - CW'(1);
      end
      if (res_push[k] && !pop[k]) begin
        rcnt_d[k] = rcnt_q[k] + CW'(1);
      end else if (!res_push[k] && pop[k]) begin
        rcnt_d[k] = rcnt_q[k] - CW'(1);
      end

      if (tag_push[k]) tag_wp_d[k] = ptr_inc(tag_wp_q[k]);
      if (res_push[k]) res_wp_d[k] = ptr_inc(res_wp_q[k]);
      if (pop[k]) begin
        tag_rp_d[k] = ptr_inc(tag_rp_q[k]);
        res_rp_d[k] = ptr_inc(res_rp_q[k]);
      end
    end

    if (hs) begin
      rr_d = (grant == UW'(NUM_UNITS - 1)) ? '0 : grant + UW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        cnt_q[k]    <= '0;
        rcnt_q[k]   <= '0;
        tag_wp_q[k] <= '0;
        tag_rp_q[k] <= '0;
        res_wp_q[k] <= '0;
        res_rp_q[k] <= '0;
      end
      rr_q        <= '0;
      lock_unit_q <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      tag_wp_q    <= tag_wp_d;
      tag_rp_q    <= tag_rp_d;
      res_wp_q    <= res_wp_d;
      res_rp_q    <= res_rp_d;
      rr_q        <= rr_d;
      lock_unit_q <= lock_unit_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage needs no reset: it is only observed through non-zero counts.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (tag_push[k]) begin
        tag_mem[k][tag_wp_q[k]] <= bus.issue_tag_i;
      end
      if (res_push[k]) begin
        res_mem[k][res_wp_q[k]] <= {bus.unit_result_i[k*DATA_WIDTH +: DATA_WIDTH],
                                    bus.unit_flags_i[k*FLAG_WIDTH +: FLAG_WIDTH]};
      end
    end
  end

  assign bus.issue_ready_o  = issue_bad | ~issue_full;
  assign bus.result_valid_o = any_valid;
  assign bus.result_o       = any_valid ? head_res[RW-1:FLAG_WIDTH] : '0;
  assign bus.flags_o        = any_valid ? head_res[FLAG_WIDTH-1:0] : '0;
  assign bus.tag_o          = any_valid ? head_tag : '0;
  assign bus.unit_o         = any_valid ? grant : '0;
  assign bus.busy_o         = busy;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// tb/tb_fpu_wb_arbiter.sv - scoreboard bench for fpu_wb_arbiter
module tb_fpu_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int FW = 5;
  localparam int TW = 5;
  localparam int D  = 2;
  localparam int UW = 2;
  localparam int FV = N * FW;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] res;
    logic [FW-1:0] flg;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fpu_wb_arbiter_if #(.NUM_UNITS(N), .DATA_WIDTH(DW), .FLAG_WIDTH(FW), .TAG_WIDTH(TW)) bus ();

  fpu_wb_arbiter #(.NUM_UNITS(N), .DATA_WIDTH(DW), .FLAG_WIDTH(FW), .TAG_WIDTH(TW),
                   .FIFO_DEPTH(D)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  // Reference model: ops waiting for data, results waiting for writeback.
  logic [TW-1:0] pend_q [N][$];
  item_t         rdy_q  [N][$];
  int  rr_m;
  bit  lock_v;
  int  lock_u;
  bit  err_m;
  bit  mon_valid;
  int  mon_unit;
  int  pre_m [N];
  int  total;
  int  bad;

  function automatic int credits(input int k);
    return pend_q[k].size() + rdy_q[k].size();
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      pend_q[k].delete();
      rdy_q[k].delete();
    end
    rr_m = 0; lock_v = 0; lock_u = 0; err_m = 0; mon_valid = 0;
  endtask

  task automatic set_idle();
    bus.issue_valid_i  = 1'b0;
    bus.issue_unit_i   = '0;
    bus.issue_tag_i    = '0;
    bus.unit_valid_i   = '0;
    bus.unit_result_i  = '0;
    bus.unit_flags_i   = '0;
    bus.result_ready_i = 1'b0;
  endtask

  task automatic drive(input bit iv, input int iu, input logic [TW-1:0] tg,
                       input logic [N-1:0] uv, input logic [N*DW-1:0] res, input bit rdy);
    bit exp_rdy;
    @(negedge clk);
    #1;
    bus.issue_valid_i  = iv;
    bus.issue_unit_i   = UW'(iu);
    bus.issue_tag_i    = tg;
    bus.unit_valid_i   = uv;
    bus.unit_result_i  = res;
    bus.unit_flags_i   = FV'($urandom);
    bus.result_ready_i = rdy;
    #1;
    if (iv) begin
      if (iu >= N) exp_rdy = 1'b1;
      else         exp_rdy = (credits(iu) < D);
      chk("issue_ready", 64'(bus.issue_ready_o), 64'(exp_rdy));
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    set_idle();
    clear_model();
    #1;
    chk("rst_valid", 64'(bus.result_valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_data", 64'({bus.result_o, bus.flags_o, bus.tag_o, bus.unit_o}), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_credits_free();
    for (int u = 0; u < N; u++) begin
      bus.issue_unit_i = UW'(u);
      #1;
      chk("credit_free", 64'(bus.issue_ready_o), 64'd1);
    end
    bus.issue_unit_i = '0;
  endtask

  // Monitor: compares presented outputs with the model's expected winner.
  initial forever begin
    int  eu;
    bit  ev;
    bit  be;
    int  ix;
    @(negedge clk);
    if (rst) begin
      mon_valid = 0;
    end else begin
      ev = 0; eu = 0; be = 0;
      for (int k = 0; k < N; k++) if (credits(k) > 0) be = 1;
      if (lock_v) begin
        ev = 1; eu = lock_u;
      end else begin
        for (int i = 0; i < N; i++) begin
          ix = (rr_m + i) % N;
          if (!ev && rdy_q[ix].size() > 0) begin
            ev = 1; eu = ix;
          end
        end
      end
      chk("result_valid", 64'(bus.result_valid_o), 64'(ev));
      if (ev) begin
        chk("payload", 64'({bus.result_o, bus.flags_o, bus.tag_o, bus.unit_o}),
            64'({rdy_q[eu][0].res, rdy_q[eu][0].flg, rdy_q[eu][0].tag, UW'(eu)}));
      end else begin
        chk("idle_zero", 64'({bus.result_o, bus.flags_o, bus.tag_o, bus.unit_o}), 64'd0);
      end
      chk("busy", 64'(bus.busy_o), 64'(be));
      chk("err", 64'(bus.err_o), 64'(err_m));
      mon_valid = ev;
      mon_unit  = eu;
    end
  end

  // Model update at each active edge from the inputs held during that cycle.
  initial forever begin
    item_t it;
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < N; k++) pre_m[k] = credits(k);
      if (mon_valid) begin
        if (bus.result_ready_i) begin
          void'(rdy_q[mon_unit].pop_front());
          rr_m   = (mon_unit + 1) % N;
          lock_v = 0;
        end else begin
          lock_v = 1;
          lock_u = mon_unit;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (bus.unit_valid_i[k]) begin
          if (pend_q[k].size() > 0) begin
            it.tag = pend_q[k].pop_front();
            it.res = bus.unit_result_i[k*DW +: DW];
            it.flg = bus.unit_flags_i[k*FW +: FW];
            rdy_q[k].push_back(it);
          end else begin
            err_m = 1;
          end
        end
      end
      if (bus.issue_valid_i) begin
        if (int'(bus.issue_unit_i) >= N) err_m = 1;
        else if (pre_m[bus.issue_unit_i] < D) pend_q[bus.issue_unit_i].push_back(bus.issue_tag_i);
      end
    end
  end

  initial begin
    logic [N*DW-1:0] rv;
    logic [N-1:0]    uv;
    int              busy_cnt;
    total = 0;
    bad   = 0;
    set_idle();
    clear_model();
    do_reset();
    check_credits_free();

    // Single op on unit 1.
    drive(1, 1, 5'd5, '0, '0, 1);
    idle(1, 1);
    rv = '0; rv[1*DW +: DW] = 32'h3F800000;
    drive(0, 0, '0, 3'b010, rv, 1);
    idle(3, 1);
    chk("single_busy_low", 64'(bus.busy_o), 64'd0);

    // Collision between units 0 and 2.
    drive(1, 0, 5'd7, '0, '0, 1);
    drive(1, 2, 5'd9, '0, '0, 1);
    rv = '0; rv[0 +: DW] = 32'h40000000; rv[2*DW +: DW] = 32'h40400000;
    drive(0, 0, '0, 3'b101, rv, 1);
    idle(3, 1);

    // Backpressure with units 0 and 1 pending.
    drive(1, 0, 5'd3, '0, '0, 0);
    drive(1, 1, 5'd4, '0, '0, 0);
    rv = '0; rv[0 +: DW] = 32'h11111111; rv[1*DW +: DW] = 32'h22222222;
    drive(0, 0, '0, 3'b011, rv, 0);
    idle(5, 0);
    idle(3, 1);

    // Credit limit on unit 2.
    drive(1, 2, 5'd10, '0, '0, 1);
    drive(1, 2, 5'd11, '0, '0, 1);
    drive(1, 2, 5'd12, '0, '0, 1);
    chk("credit_full", 64'(bus.issue_ready_o), 64'd0);
    rv = '0; rv[2*DW +: DW] = 32'hA0A0A0A0;
    drive(0, 0, '0, 3'b100, rv, 1);
    idle(1, 1);
    drive(1, 2, 5'd13, '0, '0, 1);
    chk("credit_back", 64'(bus.issue_ready_o), 64'd1);
    rv[2*DW +: DW] = 32'hB0B0B0B0;
    drive(0, 0, '0, 3'b100, rv, 1);
    rv[2*DW +: DW] = 32'hC0C0C0C0;
    drive(0, 0, '0, 3'b100, rv, 1);
    idle(3, 1);

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      uv = '0;
      for (int k = 0; k < N; k++) begin
        rv[k*DW +: DW] = $urandom;
        if (pend_q[k].size() > 0 && ($urandom % 3) == 0) uv[k] = 1'b1;
      end
      drive(($urandom % 10) < 6, $urandom % N, TW'($urandom), uv, rv, ($urandom % 4) != 0);
    end

    // Drain whatever is left.
    for (int c = 0; c < 60; c++) begin
      uv = '0;
      for (int k = 0; k < N; k++) begin
        rv[k*DW +: DW] = $urandom;
        if (pend_q[k].size() > 0) uv[k] = 1'b1;
      end
      drive(0, 0, '0, uv, rv, 1);
    end
    busy_cnt = 0;
    for (int k = 0; k < N; k++) busy_cnt += credits(k);
    chk("drain_model_empty", 64'(busy_cnt), 64'd0);
    chk("drain_busy", 64'(bus.busy_o), 64'd0);

    // Spurious strobe with no outstanding issue.
    rv = '0; rv[1*DW +: DW] = 32'hDEADBEEF;
    drive(0, 0, '0, 3'b010, rv, 1);
    idle(3, 1);
    chk("err_sticky", 64'(bus.err_o), 64'd1);
    chk("err_no_valid", 64'(bus.result_valid_o), 64'd0);

    // Invalid unit index.
    do_reset();
    drive(1, 3, 5'd1, '0, '0, 1);
    chk("bad_unit_ready", 64'(bus.issue_ready_o), 64'd1);
    idle(2, 1);
    chk("bad_unit_err", 64'(bus.err_o), 64'd1);

    // Reset with three results buffered.
    do_reset();
    drive(1, 0, 5'd20, '0, '0, 0);
    drive(1, 1, 5'd21, '0, '0, 0);
    drive(1, 2, 5'd22, '0, '0, 0);
    for (int k = 0; k < N; k++) rv[k*DW +: DW] = $urandom;
    drive(0, 0, '0, 3'b111, rv, 0);
    idle(2, 0);
    chk("pre_reset_busy", 64'(bus.busy_o), 64'd1);
    do_reset();
    check_credits_free();
    idle(2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
